// File: rtl/b_sat_pkg.sv
// rtl/b_sat_pkg.sv - shared B_VPE sizing, widths and clause-loader types
package b_sat_pkg;

    localparam int NUM_VAR    = 60;
    localparam int NUM_CLAUSE = 32;
    localparam int GROUP_SIZE = 4;

    localparam int ROW_W     = $clog2(NUM_VAR);
    localparam int IDX_W     = $clog2(NUM_CLAUSE);
    localparam int GRP_W     = NUM_CLAUSE / GROUP_SIZE;
    localparam int GRP_SHIFT = $clog2(GROUP_SIZE);
    localparam int GRP_IDX_W = IDX_W - GRP_SHIFT;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_VAR - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_FINISH = 2'd2
    } loader_state_e;

    // Polarity is stored already masked by presence.
    typedef struct packed {
        logic [IDX_W-1:0]   idx;
        logic [NUM_VAR-1:0] present;
        logic [NUM_VAR-1:0] pol;
        logic               last;
    } clause_desc_t;

endpackage

// File: rtl/b_wl_decoder.sv
// rtl/b_wl_decoder.sv - row index to one-hot wordline select
module b_wl_decoder
    import b_sat_pkg::*;
(
    input  logic [ROW_W-1:0]   row_i,
    output logic [NUM_VAR-1:0] wl_sw_o
);

    // Indices past the last row match no bit and decode to all-zero.
    always_comb begin
        wl_sw_o = '0;
        for (int i = 0; i < NUM_VAR; i++) begin
            wl_sw_o[i] = (row_i == ROW_W'(i));
        end
    end

endmodule

// File: rtl/b_clause_loader.sv
// rtl/b_clause_loader.sv - serialises clause descriptors into PE SRAM write cycles
module b_clause_loader
    import b_sat_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [IDX_W-1:0]      in_clause_idx_i,
    input  logic [NUM_VAR-1:0]    in_lit_present_i,
    input  logic [NUM_VAR-1:0]    in_lit_pol_i,
    input  logic                  in_last_i,
    output logic [NUM_VAR-1:0]    wl_sw_o,
    output logic                  wl_sign_o,
    output logic [GRP_W-1:0]      bl_en_o,
    output logic [NUM_CLAUSE-1:0] bl_si_o,
    output logic [NUM_CLAUSE-1:0] bl_sl_o,
    output logic [NUM_CLAUSE-1:0] bl_sr_o,
    output logic                  sram_state_o,
    output logic                  busy_o,
    output logic                  clause_done_o,
    output logic                  load_done_o
);

    loader_state_e state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             sign_q, sign_d;
    clause_desc_t     desc_q, desc_d;

    logic                  in_ready_q, in_ready_d;
    logic [NUM_VAR-1:0]    wl_sw_q, wl_sw_d;
    logic                  wl_sign_q, wl_sign_d;
    logic [GRP_W-1:0]      bl_en_q, bl_en_d;
    logic [NUM_CLAUSE-1:0] bl_si_q, bl_si_d;
    logic [NUM_CLAUSE-1:0] bl_sl_q, bl_sl_d;
    logic                  sram_state_q, sram_state_d;
    logic                  busy_q, busy_d;
    logic                  clause_done_q, clause_done_d;
    logic                  load_done_q, load_done_d;

    logic [NUM_VAR-1:0]    row_onehot;
    logic [GRP_IDX_W-1:0]  grp_idx;
    logic                  wr_active;
    logic                  wr_bit;

    b_wl_decoder u_wl_decoder (
        .row_i   (row_d),
        .wl_sw_o (row_onehot)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        sign_d  = sign_q;
        desc_d  = desc_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    desc_d.idx     = in_clause_idx_i;
                    desc_d.present = in_lit_present_i;
                    desc_d.pol     = in_lit_pol_i & in_lit_present_i;
                    desc_d.last    = in_last_i;
                    row_d          = '0;
                    sign_d         = 1'b0;
                    state_d        = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (row_q == LAST_ROW && sign_q) begin
                    state_d = ST_FINISH;
                end else begin
                    // Presence plane then polarity plane for each row.
                    sign_d = ~sign_q;
                    if (sign_q) begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from next state so the registered pins line up
    // with the cycle the state is entered.
    always_comb begin
        wr_active     = (state_d == ST_WRITE);
        wr_bit        = sign_d ? desc_d.pol[row_d] : desc_d.present[row_d];
        grp_idx       = desc_d.idx[IDX_W-1:GRP_SHIFT];
        in_ready_d    = (state_d == ST_IDLE);
        busy_d        = (state_d != ST_IDLE);
        sram_state_d  = wr_active;
        clause_done_d = (state_d == ST_FINISH);
        load_done_d   = (state_d == ST_FINISH) && desc_d.last;
        wl_sw_d       = '0;
        wl_sign_d     = 1'b0;
        bl_en_d       = '0;
        bl_si_d       = '0;
        bl_sl_d       = '0;
        if (wr_active) begin
            wl_sw_d              = row_onehot;
            wl_sign_d            = sign_d;
            bl_en_d[grp_idx]     = 1'b1;
            bl_sl_d[desc_d.idx]  = 1'b1;
            bl_si_d[desc_d.idx]  = wr_bit;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            row_q         <= '0;
            sign_q        <= 1'b0;
            desc_q        <= '0;
            in_ready_q    <= 1'b1;
            wl_sw_q       <= '0;
            wl_sign_q     <= 1'b0;
            bl_en_q       <= '0;
            bl_si_q       <= '0;
            bl_sl_q       <= '0;
            sram_state_q  <= 1'b0;
            busy_q        <= 1'b0;
            clause_done_q <= 1'b0;
            load_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            sign_q        <= sign_d;
            desc_q        <= desc_d;
            in_ready_q    <= in_ready_d;
            wl_sw_q       <= wl_sw_d;
            wl_sign_q     <= wl_sign_d;
            bl_en_q       <= bl_en_d;
            bl_si_q       <= bl_si_d;
            bl_sl_q       <= bl_sl_d;
            sram_state_q  <= sram_state_d;
            busy_q        <= busy_d;
            clause_done_q <= clause_done_d;
            load_done_q   <= load_done_d;
        end
    end

    assign in_ready_o    = in_ready_q;
    assign wl_sw_o       = wl_sw_q;
    assign wl_sign_o     = wl_sign_q;
    assign bl_en_o       = bl_en_q;
    assign bl_si_o       = bl_si_q;
    assign bl_sl_o       = bl_sl_q;
    assign bl_sr_o       = '0;
    assign sram_state_o  = sram_state_q;
    assign busy_o        = busy_q;
    assign clause_done_o = clause_done_q;
    assign load_done_o   = load_done_q;

endmodule
